// File: rtl/demux8_rr_scheduler_if.sv
// Bundle of the producer-side and fabric-side signals of demux8_rr_scheduler.
// slave  : scheduler view (consumes the producer stream, drives the demux select).
// master : environment view (producer plus the 8 sinks).
interface demux8_rr_scheduler_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    ch_en;
  logic [7:0]    ch_ready;
  logic [2:0]    sel;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic          drop;

  modport slave (
    input  in_valid, in_data, ch_en, ch_ready,
    output in_ready, sel, out_valid, out_data, drop
  );

  modport master (
    output in_valid, in_data, ch_en, ch_ready,
    input  in_ready, sel, out_valid, out_data, drop
  );
endinterface

// File: rtl/demux8_rr_scheduler.sv
// Round-robin scheduler with a one-entry output stage for a 1-to-8 demux.
// A word accepted from the producer is held on channel sel (one-hot
// out_valid) until that channel's ch_ready; BURST deliveries go to one
// channel before the grant rotates to the next enabled channel.
// Optional build macro DEMUX_TIMEOUT_EN: a held word stalled for TIMEOUT
// cycles is discarded with a one-cycle drop pulse.
module demux8_rr_scheduler #(
  parameter int unsigned DW      = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  demux8_rr_scheduler_if.slave  io
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;

  logic       fire;
  logic       rotate;
  logic       load;
  logic       timeout;
  logic       scan_hit;
  logic [2:0] scan_gnt;
  logic [2:0] scan_idx;
  logic       in_ready;
  logic [7:0] out_valid;
  logic       drop;

  assign fire   = (state_q == HOLD) & io.ch_ready[sel_q];
  assign rotate = (fire & (bcnt_q == 8'(BURST - 1))) | ~io.ch_en[gnt_q] | timeout;
  assign load   = io.in_valid & in_ready;

`ifdef DEMUX_TIMEOUT_EN
  logic [7:0] scnt_q, scnt_d;
  logic       stall;

  assign stall   = (state_q == HOLD) & ~io.ch_ready[sel_q];
  assign timeout = stall & (scnt_q == 8'(TIMEOUT - 1));

  // Stall counter: counts consecutive blocked HOLD cycles of the current word
  always_comb begin
    scnt_d = scnt_q;
    if (load || timeout) begin
      scnt_d = '0;
    end else if (stall) begin
      scnt_d = scnt_q + 8'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end
`else
  // No stall supervision in this build; TIMEOUT is referenced only so the
  // parameter list stays identical between builds.
  assign timeout = (TIMEOUT == 0) & 1'b0;
`endif

  // Next grant: scan gnt+1 .. gnt+7 then gnt itself, so a lone enabled
  // channel keeps the grant and an empty mask leaves it unchanged
  always_comb begin
    scan_hit = 1'b0;
    scan_gnt = gnt_q;
    scan_idx = gnt_q;
    for (int unsigned k = 1; k <= 8; k++) begin
      scan_idx = 3'(gnt_q + 3'(k));
      if (!scan_hit && io.ch_en[scan_idx]) begin
        scan_hit = 1'b1;
        scan_gnt = scan_idx;
      end
    end
    gnt_d = rotate ? scan_gnt : gnt_q;
  end

  // Burst counter, held word and select next-state
  always_comb begin
    bcnt_d = bcnt_q;
    if (rotate) begin
      bcnt_d = '0;
    end else if (fire) begin
      bcnt_d = bcnt_q + 8'd1;
    end
    sel_d  = load ? gnt_d : sel_q;
    data_d = load ? io.in_data : data_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      bcnt_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      bcnt_q <= bcnt_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a load always (re)fills the stage; fire or drop empties it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = HOLD;
      HOLD: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (fire && !load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only when the stage is empty or draining this cycle
  always_comb begin
    in_ready  = 1'b0;
    out_valid = '0;
    drop      = 1'b0;
    case (state_q)
      IDLE: in_ready = io.ch_en[gnt_d];
      HOLD: begin
        in_ready  = fire & io.ch_en[gnt_d];
        out_valid = 8'd1 << sel_q;
        drop      = timeout;
      end
      default: ;
    endcase
  end

  assign io.in_ready  = in_ready;
  assign io.sel       = sel_q;
  assign io.out_valid = out_valid;
  assign io.out_data  = data_q;
  assign io.drop      = drop;

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// Self-checking bench for demux8_rr_scheduler (BURST=2, TIMEOUT=4).
// A cycle-level reference model runs alongside directed scenarios that carry
// their own literal expectations.
module tb_demux8_rr_scheduler;

  localparam int unsigned BURST_P   = 2;
  localparam int unsigned TIMEOUT_P = 4;
`ifdef DEMUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  demux8_rr_scheduler_if #(.DW(8)) io ();

  demux8_rr_scheduler #(
    .DW     (8),
    .BURST  (BURST_P),
    .TIMEOUT(TIMEOUT_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    io.in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: evaluated on each falling edge from the inputs that
  // will be seen at the next rising edge
  initial begin : model
    bit         m_held;
    int         m_sel, m_gnt, m_bcnt, m_stall, ng;
    logic [7:0] m_data, en, rdy, exp_ov;
    bit         fire, to, rot, found, exp_rdy, load;
    m_held = 0; m_sel = 0; m_gnt = 0; m_bcnt = 0; m_stall = 0; m_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_held = 0; m_sel = 0; m_gnt = 0; m_bcnt = 0; m_stall = 0; m_data = '0;
        chk("m_rst_ov", io.out_valid, 0);
        chk("m_rst_sel", io.sel, 0);
        chk("m_rst_data", io.out_data, 0);
        chk("m_rst_drop", io.drop, 0);
      end else begin
        en  = io.ch_en;
        rdy = io.ch_ready;
        fire = m_held && rdy[m_sel];
        to   = TO_EN && m_held && !rdy[m_sel] && (m_stall == int'(TIMEOUT_P) - 1);
        rot  = (fire && m_bcnt == int'(BURST_P) - 1) || !en[m_gnt] || to;
        ng = m_gnt;
        if (rot) begin
          found = 0;
          for (int s = 1; s <= 8; s++) begin
            if (!found && en[(m_gnt + s) % 8]) begin
              found = 1;
              ng = (m_gnt + s) % 8;
            end
          end
        end
        exp_rdy = en[ng] && (!m_held || fire);
        exp_ov  = m_held ? 8'(1 << m_sel) : 8'h00;
        chk("m_ov", io.out_valid, exp_ov);
        chk("m_sel", io.sel, m_sel);
        chk("m_ready", io.in_ready, exp_rdy);
        chk("m_drop", io.drop, to);
        if (m_held) chk("m_data", io.out_data, m_data);
        load = io.in_valid && exp_rdy;
        m_bcnt = rot ? 0 : (fire ? m_bcnt + 1 : m_bcnt);
        m_gnt  = ng;
        if (load || to) m_stall = 0;
        else if (m_held && !rdy[m_sel]) m_stall = m_stall + 1;
        if (load) begin
          m_held = 1; m_sel = ng; m_data = io.in_data;
        end else if (fire || to) begin
          m_held = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int sel_t1[6] = '{0, 0, 1, 1, 2, 2};
  int sel_t2[8] = '{0, 0, 5, 5, 7, 7, 0, 0};

  initial begin : driver
    total = 0;
    bad   = 0;
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_data  = '0;
    io.ch_en    = 8'hFF;
    io.ch_ready = 8'hFF;
    @(negedge clk);
    chk("reset_ov", io.out_valid, 0);
    chk("reset_sel", io.sel, 0);
    chk("reset_data", io.out_data, 0);
    chk("reset_drop", io.drop, 0);
    tick();
    rst = 1'b0;

    // 1: continuous stream, two words per channel, 1-cycle latency
    io.in_valid = 1'b1;
    io.in_data  = 8'd10;
    @(negedge clk);
    chk("t1_ready0", io.in_ready, 1);
    chk("t1_idle_ov", io.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      io.in_data  = 8'(11 + i);
      io.in_valid = (i < 5);
      @(negedge clk);
      chk("t1_sel", io.sel, sel_t1[i]);
      chk("t1_ov", io.out_valid, 1 << sel_t1[i]);
      chk("t1_data", io.out_data, 10 + i);
      chk("t1_ready", io.in_ready, 1);
    end
    tick();
    @(negedge clk);
    chk("t1_drain", io.out_valid, 0);

    // 2: sparse mask A1, rotation skips disabled channels and wraps 7->0
    do_reset();
    io.ch_en    = 8'hA1;
    io.in_valid = 1'b1;
    io.in_data  = 8'd20;
    for (int i = 0; i < 8; i++) begin
      tick();
      io.in_data  = 8'(21 + i);
      io.in_valid = (i < 7);
      @(negedge clk);
      chk("t2_sel", io.sel, sel_t2[i]);
      chk("t2_ov", io.out_valid, 1 << sel_t2[i]);
      chk("t2_data", io.out_data, 20 + i);
    end
    tick();
    @(negedge clk);
    chk("t2_drain", io.out_valid, 0);

    // 3: word on channel 3 stalled 3 cycles, other ready bits ignored
    do_reset();
    io.ch_en    = 8'h08;
    io.ch_ready = 8'hF7;
    io.in_valid = 1'b1;
    io.in_data  = 8'h33;
    tick();
    io.in_data = 8'h44;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_ov", io.out_valid, 8'h08);
      chk("t3_stall_sel", io.sel, 3);
      chk("t3_stall_data", io.out_data, 8'h33);
      chk("t3_stall_ready", io.in_ready, 0);
      tick();
    end
    io.ch_ready = 8'h08;
    @(negedge clk);
    chk("t3_fire_ov", io.out_valid, 8'h08);
    chk("t3_fire_data", io.out_data, 8'h33);
    chk("t3_fire_ready", io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_next_data", io.out_data, 8'h44);
    tick();
    @(negedge clk);
    chk("t3_drain", io.out_valid, 0);

    // 4: empty mask blocks input; enabling channel 2 admits the next word
    do_reset();
    io.ch_en    = 8'h00;
    io.ch_ready = 8'hFF;
    io.in_valid = 1'b1;
    io.in_data  = 8'h55;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_blk_ready", io.in_ready, 0);
      chk("t4_blk_ov", io.out_valid, 0);
      tick();
    end
    io.ch_en = 8'h04;
    @(negedge clk);
    chk("t4_en_ready", io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    io.ch_ready = 8'h00;
    @(negedge clk);
    chk("t4_ov", io.out_valid, 8'h04);
    chk("t4_sel", io.sel, 2);
    chk("t4_data", io.out_data, 8'h55);
    // mask cleared while held: word still goes to channel 2
    tick();
    io.ch_en = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_dis_ov", io.out_valid, 8'h04);
      tick();
    end
    io.ch_ready = 8'h04;
    @(negedge clk);
    chk("t4_dis_fire_ov", io.out_valid, 8'h04);
    chk("t4_dis_ready", io.in_ready, 0);
    tick();
    @(negedge clk);
    chk("t4_dis_drain", io.out_valid, 0);

    // 5: asynchronous reset while holding on channel 5
    do_reset();
    io.ch_en    = 8'h20;
    io.ch_ready = 8'h00;
    io.in_valid = 1'b1;
    io.in_data  = 8'h5A;
    tick();
    io.in_valid = 1'b0;
    io.ch_en    = 8'hFF;
    @(negedge clk);
    chk("t5_hold_ov", io.out_valid, 8'h20);
    chk("t5_hold_sel", io.sel, 5);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_ov", io.out_valid, 0);
    chk("t5_rst_sel", io.sel, 0);
    chk("t5_rst_drop", io.drop, 0);
    chk("t5_rst_data", io.out_data, 0);
    tick();
    rst = 1'b0;
    io.ch_ready = 8'hFF;
    io.in_valid = 1'b1;
    io.in_data  = 8'h66;
    tick();
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_after_ov", io.out_valid, 8'h01);
    chk("t5_after_sel", io.sel, 0);
    chk("t5_after_data", io.out_data, 8'h66);
    tick();
    @(negedge clk);
    chk("t5_drain", io.out_valid, 0);

    // 6: channel never ready
    do_reset();
    io.ch_en    = 8'hFF;
    io.ch_ready = 8'h00;
    io.in_valid = 1'b1;
    io.in_data  = 8'h77;
    tick();
    io.in_data = 8'h88;
`ifdef DEMUX_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t6_stall_ov", io.out_valid, 8'h01);
      chk("t6_stall_data", io.out_data, 8'h77);
      chk("t6_stall_ready", io.in_ready, 0);
      chk("t6_drop", io.drop, (k == 4));
      tick();
    end
    @(negedge clk);
    chk("t6_post_ov", io.out_valid, 0);
    chk("t6_post_drop", io.drop, 0);
    chk("t6_post_ready", io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_next_ov", io.out_valid, 8'h02);
    chk("t6_next_sel", io.sel, 1);
    chk("t6_next_data", io.out_data, 8'h88);
    tick();
    io.ch_ready = 8'hFF;
    @(negedge clk);
    chk("t6_next_fire_ov", io.out_valid, 8'h02);
    tick();
    @(negedge clk);
    chk("t6_drain", io.out_valid, 0);
`else
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      chk("t6_wait_ov", io.out_valid, 8'h01);
      chk("t6_wait_data", io.out_data, 8'h77);
      chk("t6_wait_drop", io.drop, 0);
      tick();
    end
    io.ch_ready = 8'hFF;
    @(negedge clk);
    chk("t6_fire_ov", io.out_valid, 8'h01);
    chk("t6_fire_ready", io.in_ready, 1);
    tick();
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_next_data", io.out_data, 8'h88);
    chk("t6_next_sel", io.sel, 0);
    tick();
    @(negedge clk);
    chk("t6_drain", io.out_valid, 0);
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
